// File: rtl/tc_d_writeback.sv
// D-bank write-back engine: streams filled D SRAM banks to AXI4 as fixed INCR bursts.
// Optional TC_DWB_BRESP_CHECK_EN: non-OKAY bresp sets a sticky err flag.
module tc_d_writeback #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BANK_WORDS = 128,
  parameter int BURST_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             d_base,
  input  logic [3:0]                    n_banks,
  input  logic [1:0]                    bank_ready,
  output logic [1:0]                    bank_free,
  output logic                          sram_ren,
  output logic                          sram_bank,
  output logic [$clog2(BANK_WORDS)-1:0] sram_addr,
  input  logic [DATA_W-1:0]             sram_rdata,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [ADDR_W-1:0]             awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [DATA_W-1:0]             wdata,
  output logic [DATA_W/8-1:0]           wstrb,
  output logic                          wlast,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [1:0]                    bresp,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  localparam int PW     = $clog2(BANK_WORDS);
  localparam int NBURST = BANK_WORDS / BURST_LEN;
  localparam int BW     = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int CW     = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;
  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_rem;
  logic              r_bank;
  logic [PW-1:0]     r_ptr;
  logic [BW-1:0]     r_burst;
  logic [CW-1:0]     r_iss, r_beat;
  logic [DATA_W-1:0] r_mem [2];
  logic              r_wp, r_rp, r_inflt;
  logic [1:0]        r_cnt, r_bfree;
  logic              r_done;

  logic w_aw_hs, w_w_hs, w_b_hs, w_last_beat, w_last_burst, w_push, w_pop, w_wvalid;

  assign w_aw_hs      = awvalid & awready;
  assign w_w_hs       = w_wvalid & wready;
  assign w_b_hs       = bready & bvalid;
  assign w_last_beat  = (r_beat == CW'(BURST_LEN - 1));
  assign w_last_burst = (r_burst == BW'(NBURST - 1));

  // Data landing from the SRAM bypasses the FIFO when it is empty, so a beat can
  // leave the cycle its read returns; it is only stored if W stalls or FIFO is occupied.
  assign w_wvalid = (r_state == S_DATA) & ((r_cnt != 2'd0) | r_inflt);
  assign w_push   = r_inflt & ~((r_cnt == 2'd0) & w_w_hs);
  assign w_pop    = (r_cnt != 2'd0) & w_w_hs;

  assign busy      = (r_state != S_IDLE);
  assign awvalid   = (r_state == S_ADDR);
  assign awaddr    = r_addr;
  assign awlen     = 8'(BURST_LEN - 1);
  assign awsize    = 3'b010;
  assign awburst   = 2'b01;
  assign wstrb     = '1;
  assign wvalid    = w_wvalid;
  assign wdata     = (r_cnt != 2'd0) ? r_mem[r_rp] : sram_rdata;
  assign wlast     = w_wvalid & w_last_beat;
  assign bready    = (r_state == S_RESP);
  assign bank_free = r_bfree;
  assign done      = r_done;
  assign sram_bank = r_bank;
  assign sram_addr = r_ptr;
  assign sram_ren  = (r_state == S_DATA) && (r_iss < CW'(BURST_LEN)) &&
                     ((3'(r_cnt) + 3'(r_inflt)) < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (n_banks == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT: if (bank_ready[r_bank]) w_next = S_ADDR;
      S_ADDR: if (w_aw_hs) w_next = S_DATA;
      S_DATA: if (w_w_hs && w_last_beat) w_next = S_RESP;
      S_RESP: if (w_b_hs) begin
        if (!w_last_burst)         w_next = S_ADDR;
        else if (r_rem == 4'd1)    w_next = S_DONE;
        else                       w_next = S_WAIT;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0; r_rem <= '0; r_bank <= 1'b0; r_ptr <= '0; r_burst <= '0;
      r_iss <= '0; r_beat <= '0; r_wp <= 1'b0; r_rp <= 1'b0; r_cnt <= '0;
      r_inflt <= 1'b0; r_bfree <= '0; r_done <= 1'b0;
    end else begin
      r_bfree <= '0;
      r_done  <= (r_state == S_DONE);
      r_inflt <= sram_ren;
      case (r_state)
        S_IDLE: if (start) begin
          r_addr <= d_base; r_rem <= n_banks; r_bank <= 1'b0;
        end
        S_WAIT: if (bank_ready[r_bank]) begin
          r_ptr <= '0; r_burst <= '0;
        end
        S_ADDR: if (w_aw_hs) begin
          r_iss <= '0; r_beat <= '0;
        end
        S_RESP: if (w_b_hs) begin
          r_addr <= r_addr + ADDR_W'(BURST_LEN * 4);
          if (w_last_burst) begin
            r_bfree <= r_bank ? 2'b10 : 2'b01;
            r_bank  <= ~r_bank;
            r_rem   <= r_rem - 4'd1;
          end else begin
            r_burst <= r_burst + BW'(1);
          end
        end
        default: ;
      endcase
      if (sram_ren) begin
        r_ptr <= r_ptr + PW'(1);
        r_iss <= r_iss + CW'(1);
      end
      if (w_w_hs) r_beat <= r_beat + CW'(1);
      if (w_push) begin
        r_mem[r_wp] <= sram_rdata;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

`ifdef TC_DWB_BRESP_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst)                                          r_err <= 1'b0;
    else if (r_state == S_IDLE && start)              r_err <= 1'b0;
    else if (w_b_hs && bresp != 2'b00)                r_err <= 1'b1;
  end
  assign err = r_err;
`else
  logic w_unused_bresp;
  assign w_unused_bresp = ^bresp;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tc_d_writeback.sv
// Scoreboard bench for tc_d_writeback: expected AW/W/bank_free streams queued at job start.
module tb_tc_d_writeback;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] d_base = '0;
  logic [3:0]  n_banks = '0;
  logic [1:0]  bank_ready = 2'b11, bank_free;
  logic        sram_ren, sram_bank;
  logic [6:0]  sram_addr;
  logic [31:0] sram_rdata = '0;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready, busy, done, err;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [3:0]  wstrb;

`ifdef TC_DWB_BRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  tc_d_writeback dut (
    .clk(clk), .rst(rst), .start(start), .d_base(d_base), .n_banks(n_banks),
    .bank_ready(bank_ready), .bank_free(bank_free), .sram_ren(sram_ren),
    .sram_bank(sram_bank), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready),
    .bresp(bresp), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM model: bank0 word i = i, bank1 word i = 0x1000+i
  logic [31:0] mem [2][128];
  always @(posedge clk) if (sram_ren) sram_rdata <= mem[sram_bank][sram_addr];

  logic [31:0] q_aw[$];
  logic [32:0] q_w[$];
  logic [1:0]  q_bf[$];

  // Slave knobs
  int aw_delay = 0, b_max = 0, err_burst = -1, b_idx = 0, n_done = 0, outst = 0;
  bit wr_rand = 0;

  initial begin
    int aw_wait = 0, b_wait = 0, b_del = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(posedge clk); #1;
      awready = awvalid && (aw_wait >= aw_delay);
      if (awvalid) aw_wait++; else aw_wait = 0;
      wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bready) begin
        bvalid = (b_wait >= b_del);
        bresp  = (bvalid && b_idx == err_burst) ? 2'b10 : 2'b00;
        b_wait++;
      end else begin
        bvalid = 0; bresp = 0; b_wait = 0; b_del = $urandom_range(0, b_max);
      end
    end
  end

  logic        p_aw_stall = 0, p_w_stall = 0, p_wlast = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (p_aw_stall) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_w_stall)  chk("w_hold", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
      if (wvalid)     chk("w_after_aw", outst, 1);
      if (awvalid && awready) begin
        if (q_aw.size() == 0) chk("aw_unexp", 1, 0);
        else chk("awaddr", awaddr, q_aw.pop_front());
        outst++;
      end
      if (wvalid && wready) begin
        if (q_w.size() == 0) chk("w_unexp", 1, 0);
        else chk("wbeat", {wlast, wdata}, q_w.pop_front());
        if (wlast) outst--;
      end
      if (bvalid && bready) b_idx++;
      if (bank_free != 2'b00) begin
        if (q_bf.size() == 0) chk("bf_unexp", bank_free, 0);
        else chk("bank_free", bank_free, q_bf.pop_front());
      end
      if (done) n_done++;
      p_aw_stall = awvalid && !awready; p_awaddr = awaddr;
      p_w_stall  = wvalid && !wready;   p_wdata  = wdata; p_wlast = wlast;
    end
  end

  task automatic push_exp(input logic [31:0] base, input int nb);
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) begin
        q_aw.push_back(base + 32'((k * 8 + j) * 64));
        for (int i = 0; i < 16; i++)
          q_w.push_back({(i == 15), ((k % 2) ? 32'h1000 : 32'h0) + 32'(j * 16 + i)});
      end
      q_bf.push_back((k % 2) ? 2'b10 : 2'b01);
    end
  endtask

  task automatic kick(input logic [31:0] base, input int nb);
    b_idx = 0;
    @(posedge clk); #1 d_base = base; n_banks = 4'(nb); start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic run_job(input logic [31:0] base, input int nb, input logic exp_err, input bit hold);
    int s, cyc;
    push_exp(base, nb);
    bank_ready = hold ? 2'b10 : 2'b11;
    s = n_done;
    kick(base, nb);
    chk("start_busy", busy, 1);
    if (hold) begin
      repeat (10) @(posedge clk);
      #1 chk("wait_bank", awvalid, 0);
      bank_ready = 2'b11;
    end
    cyc = 0;
    while (n_done == s && cyc < 20000) begin @(posedge clk); cyc++; end
    #1;
    chk("job_done", n_done - s, 1);
    chk("aw_left", q_aw.size(), 0);
    chk("w_left", q_w.size(), 0);
    chk("bf_left", q_bf.size(), 0);
    chk("err", err, exp_err);
    chk("idle", busy, 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 128; i++) begin mem[0][i] = 32'(i); mem[1][i] = 32'h1000 + 32'(i); end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);   chk("rst_wlast", wlast, 0);
    chk("rst_ren", sram_ren, 0);    chk("rst_bfree", bank_free, 0);
    chk("rst_done", done, 0);       chk("rst_err", err, 0);
    chk("rst_bready", bready, 0);   chk("rst_awaddr", awaddr, 0);
    chk("awlen", awlen, 15);        chk("awsize", awsize, 2);
    chk("awburst", awburst, 1);     chk("wstrb", wstrb, 4'hf);
    rst = 0;

    run_job(32'h1000, 1, 0, 0);
    run_job(32'h1000, 3, 0, 1);
    wr_rand = 1; b_max = 7;
    run_job(32'h1000, 1, 0, 0);
    wr_rand = 0; b_max = 0;
    err_burst = 3;
    run_job(32'h1000, 1, EXP_ERR, 0);
    err_burst = -1; aw_delay = 5;
    run_job(32'h2000, 1, 0, 0);
    aw_delay = 0;

    // Reset in the middle of a burst
    push_exp(32'h1000, 1);
    kick(32'h1000, 1);
    cyc = 0;
    while (q_w.size() > 100 && cyc < 2000) begin @(posedge clk); cyc++; end
    chk("mid_reached", (q_w.size() <= 100), 1);
    #1 rst = 1;
    @(posedge clk); #1;
    chk("mrst_busy", busy, 0);    chk("mrst_awvalid", awvalid, 0);
    chk("mrst_wvalid", wvalid, 0); chk("mrst_ren", sram_ren, 0);
    chk("mrst_bready", bready, 0); chk("mrst_bfree", bank_free, 0);
    chk("mrst_done", done, 0);
    q_aw.delete(); q_w.delete(); q_bf.delete();
    outst = 0; p_aw_stall = 0; p_w_stall = 0;
    @(posedge clk); #1 rst = 0;

    // Empty job: done two cycles after start, no traffic
    cyc = n_done;
    kick(32'h3000, 0);
    chk("nb0_busy", busy, 1);  chk("nb0_done_early", done, 0);
    @(posedge clk); #1;
    chk("nb0_done", done, 1);  chk("nb0_idle", busy, 0);
    @(posedge clk); #1;
    chk("nb0_done_pulse", done, 0);
    chk("nb0_done_cnt", n_done - cyc, 1);
    chk("nb0_no_aw", q_aw.size() + q_w.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
